// File: rtl/sprite_ram_writer.sv
// Loads a 1-bit-per-pixel sprite from a 24-bit RGB stream into on-chip memory
// and serves palette-expanded pixels back through a registered read port.
module sprite_ram_writer #(
  parameter int          DEPTH    = 256,
  parameter logic [23:0] PALETTE0 = 24'h000000,
  parameter logic [23:0] PALETTE1 = 24'hFFFFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic        pix_valid,
  input  logic [23:0] pix_data,
  output logic        pix_ready,
  output logic        busy,
  output logic        done,
  output logic        bad_color,
  output logic [8:0]  fill_count,
  input  logic [18:0] read_address,
  output logic [23:0] data_Out
);

  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0] FULL     = 9'(DEPTH);
  localparam logic [18:0] RD_LIMIT = 19'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [8:0]  fill_count_reg, fill_count_next;
  logic        bad_color_reg, bad_color_next;
  logic        write_en;
  logic        write_bit;
  logic [23:0] data_out_reg;

  // Palette index storage; never reset so a partial load survives Reset.
  logic        mem [0:DEPTH-1];

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_reg      <= IDLE;
      fill_count_reg <= '0;
      bad_color_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      fill_count_reg <= fill_count_next;
      bad_color_reg  <= bad_color_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    fill_count_next = fill_count_reg;
    bad_color_next  = bad_color_reg;
    pix_ready       = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;
    write_en        = 1'b0;
    write_bit       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next      = LOAD;
          fill_count_next = '0;
          bad_color_next  = 1'b0;
        end
      end
      LOAD: begin
        busy = 1'b1;
        // The last transfer leaves us in LOAD for one cycle with ready low,
        // so done lands two cycles after that handshake.
        if (fill_count_reg == FULL) begin
          state_next = DONE;
        end else begin
          pix_ready = 1'b1;
          if (pix_valid) begin
            write_en        = 1'b1;
            fill_count_next = fill_count_reg + 9'd1;
            if (pix_data == PALETTE1) begin
              write_bit = 1'b1;
            end else if (pix_data != PALETTE0) begin
              bad_color_next = 1'b1;
            end
          end
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (write_en && Reset) begin
      mem[fill_count_reg[AW-1:0]] <= write_bit;
    end
  end

  // Read-before-write: the registered read sees the entry as it was before
  // any same-edge write.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      data_out_reg <= 24'h000000;
    end else if (read_address < RD_LIMIT) begin
      data_out_reg <= mem[read_address[AW-1:0]] ? PALETTE1 : PALETTE0;
    end else begin
      data_out_reg <= PALETTE0;
    end
  end

  assign fill_count = fill_count_reg;
  assign bad_color  = bad_color_reg;
  assign data_Out   = data_out_reg;

endmodule

// File: tb/tb_sprite_ram_writer.sv
// Directed bench for sprite_ram_writer: a cycle-level behavioural model is
// compared against the DUT every cycle, plus literal checks per scenario.
module tb_sprite_ram_writer;

  localparam int          DEPTH = 256;
  localparam logic [23:0] P0    = 24'h000000;
  localparam logic [23:0] P1    = 24'hFFFFFF;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        start = 1'b0;
  logic        pix_valid = 1'b0;
  logic [23:0] pix_data = 24'h0;
  logic [18:0] read_address = 19'h0;
  logic        pix_ready, busy, done, bad_color;
  logic [8:0]  fill_count;
  logic [23:0] data_Out;

  sprite_ram_writer #(
    .DEPTH(DEPTH), .PALETTE0(P0), .PALETTE1(P1)
  ) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .pix_valid(pix_valid),
    .pix_data(pix_data), .pix_ready(pix_ready), .busy(busy), .done(done),
    .bad_color(bad_color), .fill_count(fill_count),
    .read_address(read_address), .data_Out(data_Out)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_count = 0;
  int done_cyc = 0;
  int hs_last_cyc = 0;

  // Model: a load is "active" from the accepted start until the cycle after
  // the final pixel; done is expected on exactly one recorded cycle.
  bit          m_init = 0;
  bit          m_active = 0;
  int          m_count = 0;
  bit          m_bad = 0;
  int          m_done_cycle = -1;
  logic [23:0] m_dout = 24'h0;
  bit          m_dout_known = 0;
  bit          m_mem [DEPTH];
  bit          m_known [DEPTH];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    int c0;
    c0 = cyc;
    if (!Reset) begin
      m_init = 1;
      m_active = 0;
      m_count = 0;
      m_bad = 0;
      m_done_cycle = -1;
      m_dout = 24'h0;
      m_dout_known = 1;
    end else begin
      if (read_address < 19'(DEPTH)) begin
        m_dout_known = m_known[read_address];
        m_dout = m_mem[read_address] ? P1 : P0;
      end else begin
        m_dout_known = 1;
        m_dout = P0;
      end
      if (m_active) begin
        if (m_count < DEPTH) begin
          if (pix_valid) begin
            m_mem[m_count] = (pix_data == P1);
            m_known[m_count] = 1;
            if (pix_data != P0 && pix_data != P1) m_bad = 1;
            m_count++;
          end
        end else begin
          m_active = 0;
          m_done_cycle = c0 + 1;
        end
      end else if (c0 != m_done_cycle && start) begin
        m_active = 1;
        m_count = 0;
        m_bad = 0;
      end
    end
    cyc = c0 + 1;
  endtask

  initial forever begin
    @(posedge Clk);
    model_step();
  end

  always @(negedge Clk) begin
    if (m_init) begin
      cmp("pix_ready", pix_ready, m_active && (m_count < DEPTH));
      cmp("busy", busy, m_active);
      cmp("done", done, cyc == m_done_cycle);
      cmp("bad_color", bad_color, m_bad);
      cmp("fill_count", fill_count, m_count);
      if (m_dout_known) cmp("data_Out", data_Out, m_dout);
    end
    if (pix_valid && pix_ready && fill_count == 9'(DEPTH - 1)) hs_last_cyc = cyc;
    if (done === 1'b1) begin
      done_count++;
      done_cyc = cyc;
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [23:0] pixel(input int mode, input int i, input int bad_idx);
    if (i == bad_idx) return 24'h123456;
    case (mode)
      0:       return (i % 2 == 1) ? P1 : P0;
      1:       return (i % 2 == 1) ? P0 : P1;
      2:       return (i % 3 == 0) ? P1 : P0;
      default: return P1;
    endcase
  endfunction

  task automatic rd(input int a, input logic [23:0] exp, input string name);
    read_address = 19'(a);
    step();
    cmp(name, data_Out, exp);
  endtask

  task automatic load(input int mode, input bit throttle, input int bad_idx,
                      input int stop_after, input int rw_addr, input bit mid_start);
    int i;
    int guard;
    int d0;
    bit v;
    bit hs;
    bit rw_pending;
    i = 0;
    guard = 0;
    v = 0;
    rw_pending = 0;
    d0 = done_count;
    start = 1;
    step();
    start = 0;
    cmp("start_clears_fill", fill_count, 0);
    cmp("start_clears_bad", bad_color, 0);
    cmp("busy_in_load", busy, 1);
    while (i < stop_after && guard < 4 * DEPTH) begin
      v = throttle ? ~v : 1'b1;
      pix_valid = v;
      pix_data = pixel(mode, i, bad_idx);
      start = (mid_start && i == 50);
      if (i == rw_addr) read_address = 19'(rw_addr);
      hs = pix_valid && pix_ready;
      step();
      guard++;
      if (hs) begin
        if (i == rw_addr) begin
          cmp("rw_old", data_Out, P0);
          rw_pending = 1;
        end else if (rw_pending) begin
          cmp("rw_new", data_Out, P1);
          rw_pending = 0;
        end
        i++;
      end
    end
    start = 0;
    pix_valid = 0;
    if (i < stop_after) cmp("load_timeout", i, stop_after);
    if (stop_after == DEPTH) begin
      cmp("fill_full", fill_count, 256);
      cmp("ready_low_when_full", pix_ready, 0);
      guard = 0;
      while (done !== 1'b1 && guard < 10) begin
        step();
        guard++;
      end
      cmp("done_seen", done, 1);
      step();
      cmp("done_pulses", done_count - d0, 1);
      cmp("done_latency", done_cyc - hs_last_cyc, 2);
      cmp("idle_after_done", busy, 0);
      cmp("fill_final", fill_count, 256);
    end
    $display("load mode=%0d throttle=%0d bad_idx=%0d pixels=%0d fill=%0d bad_color=%0d",
             mode, throttle, bad_idx, i, fill_count, bad_color);
  endtask

  initial begin
    int d0;
    Reset = 0;
    step();
    step();
    cmp("rst_pix_ready", pix_ready, 0);
    cmp("rst_busy", busy, 0);
    cmp("rst_done", done, 0);
    cmp("rst_bad", bad_color, 0);
    cmp("rst_fill", fill_count, 0);
    cmp("rst_data", data_Out, 24'h000000);
    Reset = 1;
    step();
    $display("reset released");

    pix_valid = 1;
    pix_data = 24'h123456;
    repeat (3) step();
    pix_valid = 0;
    cmp("idle_valid_ignored_bad", bad_color, 0);
    cmp("idle_valid_ignored_fill", fill_count, 0);

    load(0, 0, -1, DEPTH, -1, 1);
    cmp("full_bad_clear", bad_color, 0);
    rd(0, P0, "rd_addr0");
    rd(1, P1, "rd_addr1");
    rd(300, P0, "rd_out_of_range");
    repeat (3) step();
    cmp("fill_hold_idle", fill_count, 256);

    load(1, 1, -1, DEPTH, -1, 0);
    rd(0, P1, "thr_addr0");
    rd(255, P0, "thr_addr255");

    load(0, 0, 5, DEPTH, -1, 0);
    cmp("bad_sticky", bad_color, 1);
    rd(5, P0, "bad_addr5");
    rd(6, P0, "bad_addr6");

    load(2, 0, -1, 100, -1, 0);
    Reset = 0;
    step();
    cmp("midrst_pix_ready", pix_ready, 0);
    cmp("midrst_busy", busy, 0);
    cmp("midrst_done", done, 0);
    cmp("midrst_bad", bad_color, 0);
    cmp("midrst_fill", fill_count, 0);
    cmp("midrst_data", data_Out, 24'h000000);
    Reset = 1;
    d0 = done_count;
    repeat (5) step();
    cmp("midrst_no_done", done_count - d0, 0);
    for (int a = 0; a < 100; a++) rd(a, pixel(2, a, -1), "midrst_readback");
    $display("mid-load reset readback of 100 entries");

    load(3, 0, -1, DEPTH, 7, 0);
    rd(7, P1, "rw_final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
